// File: rtl/audio_adc_rx.sv
`timescale 1ns/1ps
// WM8731 ADC I2S receiver: oversamples bclk/adclrc/adcdat in sys_clk and
// delivers left-aligned signed stereo pairs with a one-cycle valid strobe.
module audio_adc_rx #(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         sys_clk,
  input  logic                         reset,
  input  logic                         bclk,
  input  logic                         adclrc,
  input  logic                         adcdat,
  output logic signed [DATA_WIDTH-1:0] data_left,
  output logic signed [DATA_WIDTH-1:0] data_right,
  output logic                         sample_valid,
  output logic                         frame_error
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_WIDTH);

  typedef enum logic {SYNC, RECV} state_t;

  // Left-align a partially filled word; missing LSBs become zero.
  function automatic logic signed [DATA_WIDTH-1:0] align_word(
    input logic [DATA_WIDTH-1:0] sr,
    input logic [CNT_W-1:0]      cnt
  );
    return $signed(sr << (FULL - cnt));
  endfunction

  logic [SYNC_STAGES-1:0] bclk_sync, lrc_sync, dat_sync;
  logic                   bclk_d;
  logic                   rise;

  logic                   rise_p0;
  logic                   lrc_p0;
  logic                   dat_p0;

  state_t                 state, state_next;
  logic                   lrc_prev;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0]  shift_reg;
  logic signed [DATA_WIDTH-1:0] held_left;
  logic                   have_left;
  logic                   boundary;
  logic                   short_word;
  logic signed [DATA_WIDTH-1:0] word;

  logic                   vld_p1;
  logic                   err_p1;
  logic signed [DATA_WIDTH-1:0] left_p1, right_p1;

  assign rise = bclk_sync[SYNC_STAGES-1] & ~bclk_d;

  // Synchroniser and bclk edge detector
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      bclk_sync <= '0;
      lrc_sync  <= '0;
      dat_sync  <= '0;
      bclk_d    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk};
      lrc_sync  <= {lrc_sync[SYNC_STAGES-2:0], adclrc};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], adcdat};
      bclk_d    <= bclk_sync[SYNC_STAGES-1];
    end
  end

  // Stage p0: registered edge event with the line values it saw
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      rise_p0 <= 1'b0;
      lrc_p0  <= 1'b0;
    end else begin
      rise_p0 <= rise;
      lrc_p0  <= lrc_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge sys_clk) begin
    dat_p0 <= dat_sync[SYNC_STAGES-1];
  end

  always_comb begin
    state_next = state;
    boundary   = rise_p0 && (lrc_p0 != lrc_prev);
    short_word = bit_cnt < FULL;
    word       = align_word(shift_reg, bit_cnt);
    case (state)
      SYNC:    if (boundary) state_next = RECV;
      RECV:    state_next = RECV;
      default: state_next = SYNC;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) state <= SYNC;
    else       state <= state_next;
  end

  // Stage p1: capture, word commit and pair assembly
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      lrc_prev  <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      held_left <= '0;
      have_left <= 1'b0;
      vld_p1    <= 1'b0;
      err_p1    <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
      if (boundary) begin
        lrc_prev  <= lrc_p0;
        bit_cnt   <= '0;
        shift_reg <= '0;
        if (state == RECV) begin
          err_p1 <= short_word;
          if (lrc_p0) begin
            held_left <= word;
            have_left <= 1'b1;
          end else if (have_left) begin
            vld_p1    <= 1'b1;
            have_left <= 1'b0;
          end
        end
      end else if (rise_p0 && state == RECV && short_word) begin
        shift_reg <= {shift_reg[DATA_WIDTH-2:0], dat_p0};
        bit_cnt   <= bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (boundary && state == RECV && !lrc_p0 && have_left) begin
      left_p1  <= held_left;
      right_p1 <= word;
    end
  end

  // Stage p2: output registers
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      data_left    <= '0;
      data_right   <= '0;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      sample_valid <= vld_p1;
      frame_error  <= err_p1;
      if (vld_p1) begin
        data_left  <= left_p1;
        data_right <= right_p1;
      end
    end
  end

endmodule

// File: doc/audio_adc_rx.md
Name: audio_adc_rx

Overview:
- Receive side of the codec audio serial link. Deserialises the WM8731 ADC stream (I2S format, codec BCLK/ADCLRCK) into stereo sample pairs in the sys_clk domain.
- Mirror of the DAC path: delivers signed data_left/data_right words plus a one-cycle valid strobe, for loopback, metering or processing blocks.
- All codec-side inputs are oversampled by sys_clk. No logic is clocked by bclk.

Parameters:
DATA_WIDTH, 24, bits per channel word delivered; also the maximum number of bits captured per channel.
SYNC_STAGES, 2, synchroniser flops on bclk, adclrc and adcdat (minimum 2).

Ports:
sys_clk      input   1           system clock (50 MHz); must be at least 8x bclk frequency.
reset        input   1           synchronous, active-high reset.
bclk         input   1           codec bit clock (asynchronous to sys_clk).
adclrc       input   1           codec ADC L/R clock: 0 = left, 1 = right.
adcdat       input   1           codec ADC serial data, MSB first.
data_left    output  DATA_WIDTH  signed left sample of the last completed pair.
data_right   output  DATA_WIDTH  signed right sample of the last completed pair.
sample_valid output  1           one-cycle pulse: a new pair has been loaded into data_left/data_right.
frame_error  output  1           one-cycle pulse: a channel word ended with fewer than DATA_WIDTH bits.

Behaviour:
- Reset (synchronous, active-high): all outputs, shift register, bit counter, held-left register and flags go to 0; state goes to SYNC.
- Synchronisation:
  - bclk, adclrc and adcdat each pass through SYNC_STAGES flops.
  - A bclk rising edge is detected as synced bclk = 1 with previous synced bclk = 0. All actions below happen only on a detected rising edge.
- Channel boundary: on a rising edge where synced adclrc differs from lrc_prev (adclrc latched at the previous rising edge):
  - that edge is the I2S delay slot; no bit is captured;
  - the bit counter clears;
  - lrc_prev updates.
- Bit capture: on subsequent rising edges, while bit_cnt < DATA_WIDTH, shift adcdat into the shift register MSB-first and increment bit_cnt. Bits beyond DATA_WIDTH are ignored; bit_cnt saturates at DATA_WIDTH.
- Word commit at a boundary (before clearing). The finished word is the shift register left-aligned; if bit_cnt < DATA_WIDTH, missing LSBs are zero and frame_error pulses.
  - Transition 0->1 (left finished): store the word in held_left; set have_left.
  - Transition 1->0 (right finished), with have_left = 1: load data_left <= held_left and data_right <= word together, pulse sample_valid, clear have_left.
  - Transition 1->0 with have_left = 0: discard the word; no sample_valid.
- States:
  - SYNC: after reset, waits for the first adclrc boundary. No capture and no commit; frame_error is suppressed. Moves to RECV on that boundary.
  - RECV: normal operation as above. Reset is the only way back to SYNC.
- Partial frames: the first partial frame after reset is never output. The first sample_valid needs one complete left word followed by one complete right word.
- Latency: sample_valid and frame_error pulse exactly SYNC_STAGES+2 sys_clk cycles after the first sys_clk edge that samples raw bclk high at the boundary edge. data_left/data_right change in that same cycle and hold until the next pair.
- sample_valid and frame_error may assert in the same cycle. Back-to-back pairs are always at least one LRC period apart; no buffering or back-pressure.
- Reset mid-word: the partial word is dropped, outputs clear next cycle, and re-acquisition starts from SYNC.
- adclrc changing twice between rising edges (glitch): only the sampled value matters. If it returns to lrc_prev, no boundary is detected.

Test Plan:
- Reset, then two full frames with left = 24'h123456, right = 24'hABCDEF (BCLK = sys_clk/16) -> one sample_valid per frame after the first complete frame; data_left = 24'h123456, data_right = 24'hABCDEF; frame_error never asserts.
- Left = 24'h800000, right = 24'h7FFFFF -> data_left reads as -8388608, data_right as +8388607; sign preserved.
- 16-bit words, left = 16'hBEEF, right = 16'h1234 -> data_left = 24'hBEEF00, data_right = 24'h123400; frame_error pulses twice per frame.
- 32-bit slots carrying 24'hC0FFEE followed by 8'hFF -> data_left = 24'hC0FFEE, extra bits ignored, no frame_error.
- Release reset in the middle of a right word -> that word and the following left/right pair are handled per SYNC rules; first sample_valid equals the first complete left+right pair.
- Assert reset for 1 cycle mid-left-word after valid output -> outputs read 0 next cycle; next valid pair matches a fully transmitted frame only.
